// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller: forwarding
// select encodings, the per-stage tracking slot and the multi-cycle latency range.
package pipe_hazard_pkg;

  localparam int SLOT_AW = 8;  // widest register index a slot can track (NREG <= 256)
  localparam int CNT_W   = 4;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               reg_write;
    logic               mem_read;
  } slot_t;

  localparam slot_t SLOT_NONE = '0;

  function automatic bit mul_lat_ok(input int lat);
    return (lat >= 1) && (lat <= 15);
  endfunction

endpackage

// File: rtl/hazard_mul_counter.sv
// Down-counter tracking how many more cycles a multi-cycle op occupies EX.
module hazard_mul_counter
  import pipe_hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, forwarding select and stall/flush control for a 5-stage
// in-order pipeline with a multi-cycle EX op and a variable-latency data memory.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter  int NREG    = 32,
  parameter  int MUL_LAT = 4,
  parameter  int FWD_EN  = 1,
  localparam int REG_AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_is_mul,
  input  logic              id_is_branch,
  input  logic              id_redirect,
  input  logic              mem_ready,
  output logic              stall_front,
  output logic              bubble_ex,
  output logic              freeze_back,
  output logic              flush_ifid,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        fwd_br_a,
  output logic [1:0]        fwd_br_b,
  output logic              mul_busy
);

  localparam bit               FWD_ON   = (FWD_EN != 0);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

  if (!mul_lat_ok(MUL_LAT) || REG_AW > SLOT_AW) begin : g_bad_param
    $error("pipe_hazard_ctrl: MUL_LAT must be 1..15 and NREG <= 256");
  end

  function automatic logic hit(input slot_t s, input logic [SLOT_AW-1:0] r);
    return s.valid && s.reg_write && (s.rd != '0) && (s.rd == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [SLOT_AW-1:0] r,
                                         input slot_t m, input slot_t w);
    if (!FWD_ON || !use_src) return FWD_RF;
    if (hit(m, r))           return FWD_EXMEM;
    if (hit(w, r))           return FWD_MEMWB;
    return FWD_RF;
  endfunction

  slot_t              ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [REG_AW-1:0]  ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic               ex_use1_q, ex_use1_d, ex_use2_q, ex_use2_d;
  logic [SLOT_AW-1:0] rs1_x, rs2_x, ex_rs1_x, ex_rs2_x;
  logic               mem_wait, mul_busy_w, ld_use, br_ex, br_mem, any_hit;
  logic               hz_stall, stall_w, cnt_load, cnt_dec;

  assign rs1_x    = SLOT_AW'(id_rs1);
  assign rs2_x    = SLOT_AW'(id_rs2);
  assign ex_rs1_x = SLOT_AW'(ex_rs1_q);
  assign ex_rs2_x = SLOT_AW'(ex_rs2_q);

  always_comb begin
    ld_use  = ex_q.valid && ex_q.mem_read &&
              ((id_use1 && ex_q.rd == rs1_x) || (id_use2 && ex_q.rd == rs2_x));
    br_ex   = (id_use1 && hit(ex_q, rs1_x)) || (id_use2 && hit(ex_q, rs2_x));
    br_mem  = mem_q.mem_read &&
              ((id_use1 && hit(mem_q, rs1_x)) || (id_use2 && hit(mem_q, rs2_x)));
    any_hit = (id_use1 && (hit(ex_q, rs1_x) || hit(mem_q, rs1_x) || hit(wb_q, rs1_x))) ||
              (id_use2 && (hit(ex_q, rs2_x) || hit(mem_q, rs2_x) || hit(wb_q, rs2_x)));
    hz_stall = id_valid && (FWD_ON ? (ld_use || (id_is_branch && (br_ex || br_mem)))
                                   : any_hit);
  end

  // Memory wait freezes the whole back end and outranks every other stall source.
  assign mem_wait = mem_q.valid && mem_q.mem_read && !mem_ready;
  assign stall_w  = mem_wait || mul_busy_w || hz_stall;
  assign cnt_load = !mem_wait && !mul_busy_w && !hz_stall && id_valid && id_is_mul;
  assign cnt_dec  = !mem_wait;

  hazard_mul_counter u_mul_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (MUL_LOAD),
    .dec      (cnt_dec),
    .busy     (mul_busy_w)
  );

  always_comb begin
    ex_d      = ex_q;
    mem_d     = mem_q;
    wb_d      = wb_q;
    ex_rs1_d  = ex_rs1_q;
    ex_rs2_d  = ex_rs2_q;
    ex_use1_d = ex_use1_q;
    ex_use2_d = ex_use2_q;
    if (!mem_wait) begin
      wb_d = mem_q;
      if (mul_busy_w) begin
        mem_d = SLOT_NONE;
      end else begin
        mem_d = ex_q;
        if (hz_stall) begin
          ex_d = SLOT_NONE;
        end else begin
          ex_d.valid     = id_valid;
          ex_d.rd        = SLOT_AW'(id_rd);
          ex_d.reg_write = id_reg_write;
          ex_d.mem_read  = id_mem_read;
        end
        ex_rs1_d  = id_rs1;
        ex_rs2_d  = id_rs2;
        ex_use1_d = id_use1 && !hz_stall;
        ex_use2_d = id_use2 && !hz_stall;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q      <= SLOT_NONE;
      mem_q     <= SLOT_NONE;
      wb_q      <= SLOT_NONE;
      ex_rs1_q  <= '0;
      ex_rs2_q  <= '0;
      ex_use1_q <= 1'b0;
      ex_use2_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      ex_rs1_q  <= ex_rs1_d;
      ex_rs2_q  <= ex_rs2_d;
      ex_use1_q <= ex_use1_d;
      ex_use2_q <= ex_use2_d;
    end
  end

  // Counter and slots only clear at the clock edge, so outputs are masked while reset is high.
  assign stall_front = !reset && stall_w;
  assign freeze_back = !reset && mem_wait;
  assign bubble_ex   = !reset && !mem_wait && !mul_busy_w && hz_stall;
  assign flush_ifid  = !reset && id_redirect && id_valid && !stall_w;
  assign mul_busy    = !reset && mul_busy_w;

  assign fwd_a    = (reset || !ex_q.valid) ? FWD_RF : fwd_sel(ex_use1_q, ex_rs1_x, mem_q, wb_q);
  assign fwd_b    = (reset || !ex_q.valid) ? FWD_RF : fwd_sel(ex_use2_q, ex_rs2_x, mem_q, wb_q);
  assign fwd_br_a = (reset || !id_valid || !id_is_branch) ? FWD_RF
                                                          : fwd_sel(id_use1, rs1_x, mem_q, wb_q);
  assign fwd_br_b = (reset || !id_valid || !id_is_branch) ? FWD_RF
                                                          : fwd_sel(id_use2, rs2_x, mem_q, wb_q);

endmodule
